// File: rtl/mem_responder_if.sv
// Load/store request bus between the execute stage and mem_responder.
interface mem_responder_if #(
  parameter int M_WIDTH = 8
);
  logic               mem_req;
  logic               mem_we;
  logic [M_WIDTH-1:0] mem_addr;
  logic [1:0]         mem_acc_width;
  logic [M_WIDTH-1:0] wr_data;
  logic [M_WIDTH-1:0] rd_data;
  logic               mem_ready;
  logic               mem_fault;

  modport master (
    output mem_req, mem_we, mem_addr, mem_acc_width, wr_data,
    input  rd_data, mem_ready, mem_fault
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_acc_width, wr_data,
    output rd_data, mem_ready, mem_fault
  );
endinterface

// File: rtl/mem_responder.sv
// Byte-serial memory responder with wait states over an internal byte RAM.
// Define MEM_RESPONDER_ALIGN_CHECK_EN to fault misaligned accesses instead of executing them.
module mem_responder #(
  parameter int         M_WIDTH     = 8,
  parameter int         DEPTH       = 256,
  parameter int         WAIT_STATES = 1,
  parameter logic [1:0] MEM_ACC_8   = 2'b00,
  parameter logic [1:0] MEM_ACC_16  = 2'b01,
  parameter logic [1:0] MEM_ACC_32  = 2'b10
) (
  input logic            clk,
  input logic            rst_n,
  mem_responder_if.slave bus
);
  localparam int NB       = M_WIDTH / 8;
  localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW       = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam bit HAS_WAIT = (WAIT_STATES > 0);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_BEAT, S_DONE, S_RELEASE} state_t;

  state_t             state_q, state_d;
  logic [M_WIDTH-1:0] addr_q, wdata_q, asm_q, asm_nxt, rd_q;
  logic               we_q;
  logic [1:0]         last_q, idx_q, last_in;
  logic [CW-1:0]      cnt_q;
  logic [AW-1:0]      ram_addr;
  logic               misalign;
  logic [7:0]         ram [DEPTH];

  // Index of the final byte: min(2^code, NB) - 1; code 2'b11 behaves as a word.
  function automatic logic [1:0] last_of(input logic [1:0] code);
    logic [1:0] l;
    case (code)
      MEM_ACC_8:  l = 2'd0;
      MEM_ACC_16: l = 2'd1;
      MEM_ACC_32: l = 2'd3;
      default:    l = 2'd3;
    endcase
    if (int'(l) >= NB) l = 2'(NB - 1);
    return l;
  endfunction

  assign last_in = last_of(bus.mem_acc_width);

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
  logic fault_q;
  assign misalign = |(bus.mem_addr[1:0] & last_in);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                            fault_q <= 1'b0;
    else if (state_q == S_IDLE && bus.mem_req) fault_q <= misalign;

  assign bus.mem_fault = (state_q == S_DONE) & fault_q;
`else
  assign misalign      = 1'b0;
  assign bus.mem_fault = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (bus.mem_req) state_d = misalign ? S_DONE : (HAS_WAIT ? S_WAIT : S_BEAT);
      // Counter holds remaining wait cycles; leave when this one is the last.
      S_WAIT:    if (cnt_q == CW'(1)) state_d = S_BEAT;
      S_BEAT:    state_d = (idx_q == last_q) ? S_DONE : (HAS_WAIT ? S_WAIT : S_BEAT);
      S_DONE:    state_d = S_RELEASE;
      S_RELEASE: if (!bus.mem_req) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  assign ram_addr = AW'(addr_q + M_WIDTH'(idx_q));

  always_comb begin
    asm_nxt = asm_q;
    asm_nxt[8*idx_q +: 8] = ram[ram_addr];
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      last_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      asm_q   <= '0;
      rd_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.mem_req) begin
          addr_q  <= bus.mem_addr;
          wdata_q <= bus.wr_data;
          we_q    <= bus.mem_we;
          last_q  <= last_in;
          idx_q   <= '0;
          cnt_q   <= CW'(WAIT_STATES);
          asm_q   <= '0;
          if (misalign) rd_q <= '0;
        end
        S_WAIT: cnt_q <= cnt_q - CW'(1);
        S_BEAT: begin
          if (!we_q) asm_q <= asm_nxt;
          // Publish on entry to DONE so rd_data is valid alongside mem_ready.
          if (idx_q == last_q) rd_q <= we_q ? '0 : asm_nxt;
          else begin
            idx_q <= idx_q + 2'd1;
            cnt_q <= CW'(WAIT_STATES);
          end
        end
        default: ;
      endcase
    end

  // RAM is deliberately not reset; reset forces IDLE so an aborted access stops writing.
  always_ff @(posedge clk)
    if (state_q == S_BEAT && we_q) ram[ram_addr] <= wdata_q[8*idx_q +: 8];

  assign bus.rd_data   = rd_q;
  assign bus.mem_ready = (state_q == S_DONE);
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: dut_a is 8-bit with one wait state, dut_b is 32-bit with none.
module tb_mem_responder;
  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mem_responder_if #(.M_WIDTH(8))  a();
  mem_responder_if #(.M_WIDTH(32)) b();

  mem_responder #(.M_WIDTH(8),  .DEPTH(256), .WAIT_STATES(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a));
  mem_responder #(.M_WIDTH(32), .DEPTH(256), .WAIT_STATES(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b));

  // One full handshake; lat = edges from accept edge to the ready cycle, extra = ready pulses seen while req is held.
  task automatic access(input bit sel, input logic we, input logic [31:0] addr, input logic [1:0] w,
                        input logic [31:0] wd, input int hold,
                        output logic [31:0] rd, output int lat, output logic flt, output int extra);
    logic rdy;
    @(negedge clk);
    if (sel) begin
      b.mem_req = 1'b1; b.mem_we = we; b.mem_addr = addr; b.mem_acc_width = w; b.wr_data = wd;
    end else begin
      a.mem_req = 1'b1; a.mem_we = we; a.mem_addr = addr[7:0]; a.mem_acc_width = w; a.wr_data = wd[7:0];
    end
    @(posedge clk);
    #2;
    if (sel) begin
      b.mem_we = ~we; b.mem_addr = $urandom; b.mem_acc_width = 2'($urandom); b.wr_data = $urandom;
    end else begin
      a.mem_we = ~we; a.mem_addr = 8'($urandom); a.mem_acc_width = 2'($urandom); a.wr_data = 8'($urandom);
    end
    lat = 0;
    rdy = 1'b0;
    while (!rdy && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      rdy = sel ? b.mem_ready : a.mem_ready;
    end
    rd  = sel ? b.rd_data : {24'h0, a.rd_data};
    flt = sel ? b.mem_fault : a.mem_fault;
    extra = 0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (sel ? b.mem_ready : a.mem_ready) extra++;
    end
    @(negedge clk);
    if (sel) b.mem_req = 1'b0; else a.mem_req = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_reset;
    #23;
    checks++; if (a.rd_data !== 8'h0)  begin errors++; $display("FAIL reset_a_rd got=%h exp=00", a.rd_data); end
    checks++; if (a.mem_ready !== 1'b0) begin errors++; $display("FAIL reset_a_ready got=%b exp=0", a.mem_ready); end
    checks++; if (a.mem_fault !== 1'b0) begin errors++; $display("FAIL reset_a_fault got=%b exp=0", a.mem_fault); end
    checks++; if (b.rd_data !== 32'h0) begin errors++; $display("FAIL reset_b_rd got=%h exp=0", b.rd_data); end
    checks++; if (b.mem_ready !== 1'b0) begin errors++; $display("FAIL reset_b_ready got=%b exp=0", b.mem_ready); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_byte;
    logic [31:0] rd; int lat, ex; logic f;
    access(0, 1'b1, 32'h10, 2'b00, 32'hA5, 1, rd, lat, f, ex);
    checks++; if (lat !== 2)       begin errors++; $display("FAIL byte_st_lat got=%0d exp=2", lat); end
    checks++; if (rd !== 32'h0)    begin errors++; $display("FAIL byte_st_rd got=%h exp=0", rd); end
    access(0, 1'b0, 32'h10, 2'b00, 32'h0, 1, rd, lat, f, ex);
    checks++; if (rd !== 32'hA5)   begin errors++; $display("FAIL byte_ld_rd got=%h exp=a5", rd); end
    checks++; if (lat !== 2)       begin errors++; $display("FAIL byte_ld_lat got=%0d exp=2", lat); end
    checks++; if (ex !== 0)        begin errors++; $display("FAIL byte_pulse_width extra=%0d exp=0", ex); end
    checks++; if (f !== 1'b0)      begin errors++; $display("FAIL byte_fault got=%b exp=0", f); end
    // Word code on an 8-bit port collapses to a single byte.
    access(0, 1'b0, 32'h10, 2'b10, 32'h0, 1, rd, lat, f, ex);
    checks++; if (rd !== 32'hA5 || lat !== 2) begin errors++; $display("FAIL byte_wide_code rd=%h lat=%0d exp=a5/2", rd, lat); end
  endtask

  task automatic test_wrap;
    logic [31:0] rd; int lat, ex; logic f;
    access(1, 1'b1, 32'hFE, 2'b00, 32'h5A, 1, rd, lat, f, ex);
    access(1, 1'b1, 32'hFE, 2'b10, 32'h11223344, 1, rd, lat, f, ex);
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    checks++; if (lat !== 1 || f !== 1'b1) begin errors++; $display("FAIL wrap_fault lat=%0d flt=%b exp=1/1", lat, f); end
    access(1, 1'b0, 32'hFE, 2'b00, 32'h0, 1, rd, lat, f, ex);
    checks++; if (rd !== 32'h5A) begin errors++; $display("FAIL wrap_unchanged got=%h exp=5a", rd); end
`else
    checks++; if (lat !== 4 || f !== 1'b0) begin errors++; $display("FAIL wrap_st lat=%0d flt=%b exp=4/0", lat, f); end
    access(1, 1'b0, 32'hFE, 2'b00, 32'h0, 1, rd, lat, f, ex);
    checks++; if (rd !== 32'h44) begin errors++; $display("FAIL wrap_fe got=%h exp=44", rd); end
    access(1, 1'b0, 32'hFF, 2'b00, 32'h0, 1, rd, lat, f, ex);
    checks++; if (rd !== 32'h33) begin errors++; $display("FAIL wrap_ff got=%h exp=33", rd); end
    access(1, 1'b0, 32'h00, 2'b00, 32'h0, 1, rd, lat, f, ex);
    checks++; if (rd !== 32'h22) begin errors++; $display("FAIL wrap_00 got=%h exp=22", rd); end
    access(1, 1'b0, 32'h01, 2'b00, 32'h0, 1, rd, lat, f, ex);
    checks++; if (rd !== 32'h11 || lat !== 1) begin errors++; $display("FAIL wrap_01 rd=%h lat=%0d exp=11/1", rd, lat); end
    access(1, 1'b0, 32'hFE, 2'b10, 32'h0, 1, rd, lat, f, ex);
    checks++; if (rd !== 32'h11223344 || lat !== 4) begin errors++; $display("FAIL wrap_word rd=%h lat=%0d exp=11223344/4", rd, lat); end
`endif
  endtask

  task automatic test_zext;
    logic [31:0] rd; int lat, ex; logic f;
    access(1, 1'b1, 32'h20, 2'b10, 32'hFFFFFFFF, 1, rd, lat, f, ex);
    checks++; if (lat !== 4 || rd !== 32'h0) begin errors++; $display("FAIL zext_fill lat=%0d rd=%h exp=4/0", lat, rd); end
    access(1, 1'b1, 32'h20, 2'b00, 32'h80, 1, rd, lat, f, ex);
    access(1, 1'b0, 32'h20, 2'b00, 32'h0, 1, rd, lat, f, ex);
    checks++; if (rd !== 32'h00000080) begin errors++; $display("FAIL zext_byte got=%h exp=00000080", rd); end
    checks++; if (lat !== 1)           begin errors++; $display("FAIL zext_byte_lat got=%0d exp=1", lat); end
    access(1, 1'b0, 32'h20, 2'b01, 32'h0, 1, rd, lat, f, ex);
    checks++; if (rd !== 32'h0000FF80 || lat !== 2) begin errors++; $display("FAIL zext_half rd=%h lat=%0d exp=0000ff80/2", rd, lat); end
    access(1, 1'b0, 32'h20, 2'b11, 32'h0, 1, rd, lat, f, ex);
    checks++; if (rd !== 32'hFFFFFF80 || lat !== 4) begin errors++; $display("FAIL code11_word rd=%h lat=%0d exp=ffffff80/4", rd, lat); end
  endtask

  task automatic test_held;
    logic [31:0] rd; int lat, ex; logic f;
    access(0, 1'b0, 32'h10, 2'b00, 32'h0, 5, rd, lat, f, ex);
    checks++; if (ex !== 0)       begin errors++; $display("FAIL held_extra_pulse got=%0d exp=0", ex); end
    checks++; if (rd !== 32'hA5)  begin errors++; $display("FAIL held_rd got=%h exp=a5", rd); end
    checks++; if (a.rd_data !== 8'hA5) begin errors++; $display("FAIL held_rd_stable got=%h exp=a5", a.rd_data); end
    access(0, 1'b1, 32'h11, 2'b00, 32'h3C, 1, rd, lat, f, ex);
    checks++; if (lat !== 2)      begin errors++; $display("FAIL back_to_back_lat got=%0d exp=2", lat); end
    access(0, 1'b0, 32'h11, 2'b00, 32'h0, 1, rd, lat, f, ex);
    checks++; if (rd !== 32'h3C)  begin errors++; $display("FAIL back_to_back_rd got=%h exp=3c", rd); end
  endtask

  task automatic test_misalign;
    logic [31:0] rd; int lat, ex; logic f;
    access(1, 1'b1, 32'h03, 2'b00, 32'h77, 1, rd, lat, f, ex);
    access(1, 1'b1, 32'h04, 2'b00, 32'h66, 1, rd, lat, f, ex);
    access(1, 1'b1, 32'h03, 2'b01, 32'hBEEF, 1, rd, lat, f, ex);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mis_st_rd got=%h exp=0", rd); end
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    checks++; if (lat !== 1 || f !== 1'b1) begin errors++; $display("FAIL mis_st_fault lat=%0d flt=%b exp=1/1", lat, f); end
    access(1, 1'b0, 32'h03, 2'b00, 32'h0, 1, rd, lat, f, ex);
    checks++; if (rd !== 32'h77 || f !== 1'b0) begin errors++; $display("FAIL mis_ram_kept rd=%h flt=%b exp=77/0", rd, f); end
    access(1, 1'b0, 32'h03, 2'b01, 32'h0, 1, rd, lat, f, ex);
    checks++; if (rd !== 32'h0 || f !== 1'b1 || lat !== 1) begin errors++; $display("FAIL mis_ld rd=%h flt=%b lat=%0d exp=0/1/1", rd, f, lat); end
`else
    checks++; if (lat !== 2 || f !== 1'b0) begin errors++; $display("FAIL mis_st_done lat=%0d flt=%b exp=2/0", lat, f); end
    access(1, 1'b0, 32'h04, 2'b00, 32'h0, 1, rd, lat, f, ex);
    checks++; if (rd !== 32'hBE) begin errors++; $display("FAIL mis_hi_byte got=%h exp=be", rd); end
    access(1, 1'b0, 32'h03, 2'b01, 32'h0, 1, rd, lat, f, ex);
    checks++; if (rd !== 32'hBEEF || f !== 1'b0 || lat !== 2) begin errors++; $display("FAIL mis_ld rd=%h flt=%b lat=%0d exp=beef/0/2", rd, f, lat); end
`endif
  endtask

  task automatic test_abort;
    logic [31:0] rd; int lat, ex; logic f; int pulses;
    access(1, 1'b1, 32'h40, 2'b10, 32'h0, 1, rd, lat, f, ex);
    access(1, 1'b1, 32'h43, 2'b00, 32'h9C, 1, rd, lat, f, ex);
    access(1, 1'b0, 32'h40, 2'b10, 32'h0, 1, rd, lat, f, ex);
    checks++; if (rd !== 32'h9C000000) begin errors++; $display("FAIL abort_pre got=%h exp=9c000000", rd); end
    @(negedge clk);
    b.mem_req = 1'b1; b.mem_we = 1'b1; b.mem_addr = 32'h40; b.mem_acc_width = 2'b10; b.wr_data = 32'hDDCCBBAA;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++; if (b.rd_data !== 32'h0 || b.mem_ready !== 1'b0) begin errors++; $display("FAIL abort_async_b rd=%h rdy=%b exp=0/0", b.rd_data, b.mem_ready); end
    checks++; if (a.rd_data !== 8'h0) begin errors++; $display("FAIL abort_async_a rd=%h exp=00", a.rd_data); end
    @(negedge clk);
    b.mem_req = 1'b0;
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (b.mem_ready) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_no_ready got=%0d exp=0", pulses); end
    access(1, 1'b0, 32'h40, 2'b10, 32'h0, 1, rd, lat, f, ex);
    checks++; if (rd !== 32'h9C00BBAA) begin errors++; $display("FAIL abort_partial got=%h exp=9c00bbaa", rd); end
  endtask

  initial begin
    rst_n = 1'b0;
    a.mem_req = 1'b0; a.mem_we = 1'b0; a.mem_addr = '0; a.mem_acc_width = 2'b00; a.wr_data = '0;
    b.mem_req = 1'b0; b.mem_we = 1'b0; b.mem_addr = '0; b.mem_acc_width = 2'b00; b.wr_data = '0;
    test_reset;
    test_byte;
    test_wrap;
    test_zext;
    test_held;
    test_misalign;
    test_abort;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
